// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM state encoding, prefix scan codes
// and small decode helpers used by the frame controller.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // A prefix byte only modifies the next key event; it never produces one itself.
    function automatic logic is_prefix(input logic [7:0] code);
        return (code == PS2_EXT) || (code == PS2_BRK);
    endfunction

    // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_hold.sv
// Single-entry valid/ack holding register for decoded key events, with a sticky
// overrun flag raised when an event arrives while the previous one is still pending.
module ps2_evt_hold (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_valid,
    input  logic [7:0] evt_code,
    input  logic       evt_ext,
    input  logic       evt_brk,
    input  logic       key_ack,
    input  logic       err_clr,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       overrun
);

    logic slot_free;
    logic evt_drop;

    // An ack in the same cycle frees the slot for the incoming event.
    assign slot_free = ~key_valid | key_ack;
    assign evt_drop  = evt_valid & ~slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (evt_valid && slot_free) begin
                key_valid <= 1'b1;
                key_code  <= evt_code;
                key_ext   <= evt_ext;
                key_break <= evt_brk;
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end

            if (evt_drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_ctrl.sv
// PS/2 receive controller: samples the debounced keyboard clock/data pair, checks
// 11-bit frames, folds E0/F0 prefixes and hands key events to a holding register.
module ps2_frame_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned TMO_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    input  logic       key_ack,
    input  logic       err_clr,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(TIMEOUT_CYC);

    ps2_state_e       state_q;
    logic             kbd_clk_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shreg_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             good_q;
    logic [7:0]       byte_q;
    logic             ext_f_q;
    logic             brk_f_q;
    logic             frame_err_q;

    logic fall;
    logic tmo_hit;
    logic evt_valid;

    assign fall      = kbd_clk_q & ~kbd_clk;
    assign tmo_hit   = (state_q != StIdle) && (tmo_q == TmoLimit);
    assign frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kbd_clk_q   <= 1'b1;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            good_q      <= 1'b0;
            byte_q      <= 8'h00;
            ext_f_q     <= 1'b0;
            brk_f_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            kbd_clk_q   <= kbd_clk;
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == StIdle || fall) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            // Prefix folding runs the cycle after a good stop bit.
            if (good_q) begin
                if (byte_q == PS2_EXT) begin
                    ext_f_q <= 1'b1;
                end else if (byte_q == PS2_BRK) begin
                    brk_f_q <= 1'b1;
                end else begin
                    ext_f_q <= 1'b0;
                    brk_f_q <= 1'b0;
                end
            end

            if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (!kbd_data) begin
                            state_q  <= StData;
                            bitcnt_q <= 3'd0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    StData: begin
                        shreg_q  <= {kbd_data, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_q   <= kbd_data;
                        state_q <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (kbd_data && parity_ok(shreg_q, par_q)) begin
                            good_q <= 1'b1;
                            byte_q <= shreg_q;
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_f_q     <= 1'b0;
                            brk_f_q     <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (tmo_hit) begin
                state_q     <= StIdle;
                frame_err_q <= 1'b1;
                ext_f_q     <= 1'b0;
                brk_f_q     <= 1'b0;
            end
        end
    end

    assign evt_valid = good_q & ~is_prefix(byte_q);

    ps2_evt_hold u_evt_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_valid (evt_valid),
        .evt_code  (byte_q),
        .evt_ext   (ext_f_q),
        .evt_brk   (brk_f_q),
        .key_ack   (key_ack),
        .err_clr   (err_clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .overrun   (overrun)
    );

endmodule
